// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, owner IDs and the
// fixed-priority-with-alternation pick used when IFU and LSU collide.
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IFU_REQ  = 3'd1,
        ARB_IFU_WAIT = 3'd2,
        ARB_LSU_REQ  = 3'd3,
        ARB_LSU_WAIT = 3'd4
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IFU = 1'b0,
        ARB_OWNER_LSU = 1'b1
    } arb_owner_e;

    localparam logic [3:0] MEM_WMASK_WORD = 4'b1111;

    // On a tie the unit that did not own the previous transaction wins.
    function automatic arb_owner_e arb_pick(input logic ifu_req, input logic lsu_req,
                                            input arb_owner_e last_owner);
        arb_owner_e win;
        if (ifu_req && lsu_req) begin
            if (last_owner == ARB_OWNER_LSU) win = ARB_OWNER_IFU;
            else                             win = ARB_OWNER_LSU;
        end else if (ifu_req) begin
            win = ARB_OWNER_IFU;
        end else begin
            win = ARB_OWNER_LSU;
        end
        return win;
    endfunction

endpackage

// File: rtl/ysyx_22041211_arb_watchdog.sv
// Response watchdog: counts waiting cycles and flags expiry on the TIMEOUT-th
// consecutive enabled cycle, so the error response lands TIMEOUT cycles after grant.
module ysyx_22041211_arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU, one transaction at a
// time, alternating priority on contention and timing out stuck responses.
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_i,
    input  logic [ADDR_LEN-1:0] ifu_addr_i,
    output logic                ifu_gnt_o,
    output logic                ifu_rvalid_o,
    output logic [DATA_LEN-1:0] ifu_rdata_o,
    output logic                ifu_err_o,

    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_LEN-1:0] lsu_addr_i,
    input  logic [DATA_LEN-1:0] lsu_wdata_i,
    input  logic [3:0]          lsu_wmask_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_LEN-1:0] lsu_rdata_o,
    output logic                lsu_err_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [3:0]          mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i
);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [ADDR_LEN-1:0] addr_q,  addr_d;
    logic                we_q,    we_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;

    arb_owner_e win;
    logic       in_wait;
    logic       wd_expire;

    assign win     = arb_pick(ifu_req_i, lsu_req_i, owner_q);
    assign in_wait = (state_q == ARB_IFU_WAIT) || (state_q == ARB_LSU_WAIT);

    ysyx_22041211_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_wait),
        .en_i     (in_wait && !mem_rvalid_i),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ARB_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= ARB_OWNER_LSU;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Next state; the request is latched so memory never sees req_i combinationally.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            ARB_IDLE: begin
                if (ifu_req_i || lsu_req_i) begin
                    owner_d = win;
                    if (win == ARB_OWNER_IFU) begin
                        state_d = ARB_IFU_REQ;
                        addr_d  = ifu_addr_i;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        wmask_d = MEM_WMASK_WORD;
                    end else begin
                        state_d = ARB_LSU_REQ;
                        addr_d  = lsu_addr_i;
                        we_d    = lsu_we_i;
                        wdata_d = lsu_wdata_i;
                        wmask_d = lsu_wmask_i;
                    end
                end
            end
            ARB_IFU_REQ:  if (mem_gnt_i) state_d = mem_rvalid_i ? ARB_IDLE : ARB_IFU_WAIT;
            ARB_LSU_REQ:  if (mem_gnt_i) state_d = mem_rvalid_i ? ARB_IDLE : ARB_LSU_WAIT;
            ARB_IFU_WAIT: if (mem_rvalid_i || wd_expire) state_d = ARB_IDLE;
            ARB_LSU_WAIT: if (mem_rvalid_i || wd_expire) state_d = ARB_IDLE;
            default:      state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ifu_gnt_o    = 1'b0;
        ifu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        ifu_err_o    = 1'b0;
        lsu_gnt_o    = 1'b0;
        lsu_rvalid_o = 1'b0;
        lsu_rdata_o  = '0;
        lsu_err_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_wmask_o  = '0;
        if ((state_q == ARB_IFU_REQ) || (state_q == ARB_LSU_REQ)) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_wmask_o = wmask_q;
        end
        // A real response beats an expiry landing in the same cycle.
        case (state_q)
            ARB_IFU_REQ: begin
                ifu_gnt_o = mem_gnt_i;
                if (mem_gnt_i && mem_rvalid_i) begin
                    ifu_rvalid_o = 1'b1;
                    ifu_rdata_o  = mem_rdata_i;
                end
            end
            ARB_IFU_WAIT: begin
                if (mem_rvalid_i) begin
                    ifu_rvalid_o = 1'b1;
                    ifu_rdata_o  = mem_rdata_i;
                end else if (wd_expire) begin
                    ifu_rvalid_o = 1'b1;
                    ifu_err_o    = 1'b1;
                end
            end
            ARB_LSU_REQ: begin
                lsu_gnt_o = mem_gnt_i;
                if (mem_gnt_i && mem_rvalid_i) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_rdata_o  = we_q ? '0 : mem_rdata_i;
                end
            end
            ARB_LSU_WAIT: begin
                if (mem_rvalid_i) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_rdata_o  = we_q ? '0 : mem_rdata_i;
                end else if (wd_expire) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_err_o    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_ysyx_22041211_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_i = 1'b0;
    logic [AW-1:0] ifu_addr_i = '0;
    logic          ifu_gnt_o, ifu_rvalid_o, ifu_err_o;
    logic [DW-1:0] ifu_rdata_o;
    logic          lsu_req_i = 1'b0, lsu_we_i = 1'b0;
    logic [AW-1:0] lsu_addr_i = '0;
    logic [DW-1:0] lsu_wdata_i = '0;
    logic [3:0]    lsu_wmask_i = '0;
    logic          lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [DW-1:0] lsu_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_wmask_o;
    logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter #(
        .DATA_LEN (DW),
        .ADDR_LEN (AW),
        .TIMEOUT  (TO),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_i    (ifu_req_i),
        .ifu_addr_i   (ifu_addr_i),
        .ifu_gnt_o    (ifu_gnt_o),
        .ifu_rvalid_o (ifu_rvalid_o),
        .ifu_rdata_o  (ifu_rdata_o),
        .ifu_err_o    (ifu_err_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_wmask_i  (lsu_wmask_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .lsu_err_o    (lsu_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Requesters must hold req until granted.
    logic ifu_hold_q = 1'b0, lsu_hold_q = 1'b0;
    always @(posedge clk) begin
        if (rst && ifu_hold_q) assert (ifu_req_i) else $error("ifu_req_i dropped before ifu_gnt_o");
        if (rst && lsu_hold_q) assert (lsu_req_i) else $error("lsu_req_i dropped before lsu_gnt_o");
        ifu_hold_q <= rst && ifu_req_i && !ifu_gnt_o;
        lsu_hold_q <= rst && lsu_req_i && !lsu_gnt_o;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic          e_mem_req, e_mem_we, e_mem_care, e_wd_care;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata;
    logic [3:0]    e_mem_wmask;
    logic          e_ifu_gnt, e_ifu_rvalid, e_ifu_err;
    logic [DW-1:0] e_ifu_rdata;
    logic          e_lsu_gnt, e_lsu_rvalid, e_lsu_err;
    logic [DW-1:0] e_lsu_rdata;

    // Requester-side model state: pending requests and their payloads.
    logic          ifu_pend = 1'b0, lsu_pend = 1'b0;
    logic [AW-1:0] ifu_a = '0, lsu_a = '0;
    logic          lsu_w = 1'b0;
    logic [DW-1:0] lsu_d = '0;
    logic [3:0]    lsu_m = '0;
    int            last_win = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic clear_exp();
        e_mem_req = 0; e_mem_we = 0; e_mem_care = 1; e_wd_care = 1;
        e_mem_addr = '0; e_mem_wdata = '0; e_mem_wmask = '0;
        e_ifu_gnt = 0; e_ifu_rvalid = 0; e_ifu_err = 0; e_ifu_rdata = '0;
        e_lsu_gnt = 0; e_lsu_rvalid = 0; e_lsu_err = 0; e_lsu_rdata = '0;
    endtask

    task automatic expect_rsp(input int win, input logic store, input logic [DW-1:0] d, input logic err);
        logic [DW-1:0] v;
        v = (store || err) ? '0 : d;
        if (win == 0) begin e_ifu_rvalid = 1; e_ifu_err = err; e_ifu_rdata = v; end
        else          begin e_lsu_rvalid = 1; e_lsu_err = err; e_lsu_rdata = v; end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("mem_req_o", 64'(mem_req_o), 64'(e_mem_req));
        if (e_mem_care) begin
            check("mem_we_o",    64'(mem_we_o),    64'(e_mem_we));
            check("mem_addr_o",  64'(mem_addr_o),  64'(e_mem_addr));
            check("mem_wmask_o", 64'(mem_wmask_o), 64'(e_mem_wmask));
            if (e_wd_care) check("mem_wdata_o", 64'(mem_wdata_o), 64'(e_mem_wdata));
        end
        check("ifu_gnt_o",    64'(ifu_gnt_o),    64'(e_ifu_gnt));
        check("ifu_rvalid_o", 64'(ifu_rvalid_o), 64'(e_ifu_rvalid));
        check("ifu_rdata_o",  64'(ifu_rdata_o),  64'(e_ifu_rdata));
        if (e_ifu_rvalid) check("ifu_err_o", 64'(ifu_err_o), 64'(e_ifu_err));
        check("lsu_gnt_o",    64'(lsu_gnt_o),    64'(e_lsu_gnt));
        check("lsu_rvalid_o", 64'(lsu_rvalid_o), 64'(e_lsu_rvalid));
        check("lsu_rdata_o",  64'(lsu_rdata_o),  64'(e_lsu_rdata));
        if (e_lsu_rvalid) check("lsu_err_o", 64'(lsu_err_o), 64'(e_lsu_err));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        ifu_req_i = ifu_pend; ifu_addr_i = ifu_a;
        lsu_req_i = lsu_pend; lsu_addr_i = lsu_a;
        lsu_we_i = lsu_w; lsu_wdata_i = lsu_d; lsu_wmask_i = lsu_m;
    endtask

    task automatic junk_mem();
        mem_gnt_i = 1'($urandom % 2); mem_rvalid_i = 1'($urandom % 2); mem_rdata_i = $urandom;
    endtask

    // One idle cycle with no requests; stray memory responses must be ignored.
    task automatic idle_cycle(input logic rv);
        drive_reqs(); mem_gnt_i = 1'($urandom % 2); mem_rvalid_i = rv; mem_rdata_i = $urandom;
        clear_exp(); cycle();
    endtask

    // gdly: REQ cycles before grant; rdly: 0 = same-cycle data, 1..TO = data in
    // that WAIT cycle, larger = no data (error on WAIT cycle TO).
    task automatic txn(input int gdly, input int rdly, input logic [DW-1:0] rdat);
        int            win;
        logic [AW-1:0] wa;
        logic          ww;
        logic [DW-1:0] wd;
        logic [3:0]    wm;
        bit            done;
        drive_reqs(); junk_mem(); clear_exp(); cycle();
        if (ifu_pend && lsu_pend) win = (last_win == 1) ? 0 : 1;
        else                      win = ifu_pend ? 0 : 1;
        last_win = win;
        if (win == 0) begin wa = ifu_a; ww = 0;     wd = '0;    wm = 4'hF;  end
        else          begin wa = lsu_a; ww = lsu_w; wd = lsu_d; wm = lsu_m; end
        done = 0;
        for (int i = 0; i <= gdly; i++) begin
            clear_exp();
            e_mem_req = 1; e_mem_addr = wa; e_mem_we = ww; e_mem_wdata = wd; e_mem_wmask = wm;
            e_wd_care = (win == 1);
            mem_gnt_i    = (i == gdly);
            mem_rvalid_i = (i == gdly) ? (rdly == 0) : 1'($urandom % 2);
            mem_rdata_i  = (i == gdly && rdly == 0) ? rdat : $urandom;
            if (i == gdly) begin
                if (win == 0) e_ifu_gnt = 1; else e_lsu_gnt = 1;
                if (rdly == 0) begin expect_rsp(win, ww, rdat, 0); done = 1; end
            end
            cycle();
        end
        if (win == 0) begin ifu_pend = 0; ifu_req_i = 0; end
        else          begin lsu_pend = 0; lsu_req_i = 0; end
        for (int w = 1; !done; w++) begin
            clear_exp(); e_mem_care = 0;
            mem_gnt_i = 1'($urandom % 2);
            mem_rvalid_i = (w == rdly);
            mem_rdata_i = (w == rdly) ? rdat : $urandom;
            if (w == rdly)    begin expect_rsp(win, ww, rdat, 0); done = 1; end
            else if (w == TO) begin expect_rsp(win, 0, '0, 1);    done = 1; end
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset held with both units requesting.
        ifu_pend = 1; ifu_a = 32'h8000_0000;
        lsu_pend = 1; lsu_a = 32'h8000_2000; lsu_w = 0; lsu_d = $urandom; lsu_m = 4'hF;
        drive_reqs();
        @(posedge clk); #1;
        repeat (3) begin junk_mem(); clear_exp(); cycle(); end
        rst = 1; last_win = 1;

        // Contention: IFU first (fetch of 0x00100073), then alternating.
        txn(0, 2, 32'h0010_0073);
        for (int k = 0; k < 3; k++) begin
            if (!ifu_pend) begin ifu_pend = 1; ifu_a = $urandom; end
            if (!lsu_pend) begin lsu_pend = 1; lsu_a = $urandom; lsu_w = 1'($urandom % 2); lsu_d = $urandom; lsu_m = 4'($urandom); end
            txn(int'($urandom % 3), int'($urandom % 3) + 1, $urandom);
        end
        txn(1, 1, $urandom);

        // Store with zero-latency memory.
        lsu_pend = 1; lsu_a = 32'h8000_1000; lsu_w = 1; lsu_d = 32'hDEAD_BEEF; lsu_m = 4'b0011;
        txn(0, 0, $urandom);

        // Timeout, then a late response must be dropped.
        lsu_pend = 1; lsu_a = $urandom; lsu_w = 0;
        txn(1, 99, $urandom);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Reset while waiting for a fetch response.
        ifu_pend = 1; ifu_a = 32'h8000_0040;
        drive_reqs(); mem_gnt_i = 0; mem_rvalid_i = 0; clear_exp(); cycle();
        clear_exp(); e_mem_req = 1; e_mem_addr = ifu_a; e_mem_wmask = 4'hF; e_wd_care = 0;
        e_ifu_gnt = 1; mem_gnt_i = 1; cycle();
        ifu_pend = 0; ifu_req_i = 0;
        rst = 0; mem_gnt_i = 0; clear_exp(); e_mem_care = 0; cycle();
        rst = 1; last_win = 1;
        idle_cycle(1'b1);
        ifu_pend = 1; ifu_a = $urandom;
        txn(0, 1, $urandom);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if (!ifu_pend && ($urandom % 3 != 0)) begin ifu_pend = 1; ifu_a = $urandom; end
            if (!lsu_pend && ($urandom % 3 != 0)) begin
                lsu_pend = 1; lsu_a = $urandom; lsu_w = 1'($urandom % 2);
                lsu_d = $urandom; lsu_m = 4'($urandom);
            end
            if (!ifu_pend && !lsu_pend) idle_cycle(1'($urandom % 2));
            else txn(int'($urandom % 3), int'($urandom % (TO + 3)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
